iopmp_err_capture: RTL and testbench

- Error-record stage directly upstream of the IOPMP control port.
- Takes single-cycle violation events from the IOPMP checker and holds the first one as a sticky error record.
- Counts faults that arrive while the record is full, raises an interrupt, and drives the record into the control port's error_report_i input as an error_registers_t.
- Software clears the record through the control port (err_clr_i pulse).

---
 rtl/iopmp_err_capture_pkg.sv | 37 +++
 rtl/iopmp_err_capture_if.sv | 21 ++
 rtl/iopmp_err_capture_sat_cnt.sv | 32 +++
 rtl/iopmp_err_capture.sv | 100 ++++++++++
 tb/tb_iopmp_err_capture.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/iopmp_err_capture_pkg.sv
// Shared types and encodings for the IOPMP error-capture stage.
package iopmp_pkg;

  localparam int IOPMPRegions = 16;
  localparam int NUM_MASTERS  = 4;
  localparam int NUM_ENTRIES  = IOPMPRegions;
  localparam int RW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int EW = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

  // Transaction type encodings
  localparam logic [1:0] TTYPE_READ  = 2'd1;
  localparam logic [1:0] TTYPE_WRITE = 2'd2;
  localparam logic [1:0] TTYPE_EXEC  = 2'd3;

  // Error type encodings
  localparam logic [2:0] ETYPE_ILL_READ  = 3'd1;
  localparam logic [2:0] ETYPE_ILL_WRITE = 3'd2;
  localparam logic [2:0] ETYPE_ILL_EXEC  = 3'd3;
  localparam logic [2:0] ETYPE_PARTIAL   = 3'd4;
  localparam logic [2:0] ETYPE_NO_HIT    = 3'd5;

  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } err_state_e;

  typedef struct packed {
    logic                   v;
    logic [1:0]             ttype;
    logic [2:0]             etype;
    logic [RW-1:0]          rrid;
    logic [EW-1:0]          eid;
    logic [33:0]            addr;
    logic [NUM_MASTERS-1:0] svw;
  } error_registers_t;

endpackage

// File: rtl/iopmp_err_capture_if.sv
// Violation event bus from the IOPMP checker into the error-capture stage.
interface iopmp_err_capture_if;
  import iopmp_pkg::*;

  logic          viol_valid_i;
  logic [RW-1:0] viol_rrid_i;
  logic [33:0]   viol_addr_i;
  logic [1:0]    viol_ttype_i;
  logic [2:0]    viol_etype_i;
  logic [EW-1:0] viol_eid_i;

  modport master (
    output viol_valid_i, viol_rrid_i, viol_addr_i,
           viol_ttype_i, viol_etype_i, viol_eid_i
  );

  modport slave (
    input  viol_valid_i, viol_rrid_i, viol_addr_i,
           viol_ttype_i, viol_etype_i, viol_eid_i
  );
endinterface

// File: rtl/iopmp_err_capture_sat_cnt.sv
// Saturating up-counter; clear wins over increment.
module iopmp_sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: clear, else increment unless already at all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/iopmp_err_capture.sv
// Sticky first-fault error record for the IOPMP control port.
// Optional multi-fault requestor bitmap (svw) enabled by IOPMP_ERR_MFR_EN;
// without it error_report_o.svw stays 0.
//
// state | meaning
// IDLE  | record empty, next violation is captured
// HELD  | record valid, later violations only counted
module iopmp_err_capture
  import iopmp_pkg::*;
#(
  parameter int OVF_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  iopmp_err_capture_if.slave    viol,
  input  logic                  err_clr_i,
  input  logic                  intr_en_i,
  output error_registers_t      error_report_o,
  output logic [OVF_CNT_W-1:0]  ovf_cnt_o,
  output logic                  intr_o
);

  err_state_e       state_q, state_d;
  error_registers_t rec_q, rec_d, new_rec;
  logic             intr_q, intr_d;
  logic             cnt_inc, cnt_clr;

  // Record image of the incoming violation; svw always starts empty
  always_comb begin
    new_rec       = '0;
    new_rec.v     = 1'b1;
    new_rec.ttype = viol.viol_ttype_i;
    new_rec.etype = viol.viol_etype_i;
    new_rec.rrid  = viol.viol_rrid_i;
    new_rec.eid   = viol.viol_eid_i;
    new_rec.addr  = viol.viol_addr_i;
  end

  // Next state, record and counter controls; a clear is applied before a coincident capture
  always_comb begin
    state_d = state_q;
    rec_d   = rec_q;
    cnt_inc = 1'b0;
    cnt_clr = 1'b0;
    case (state_q)
      IDLE: begin
        if (viol.viol_valid_i) begin
          rec_d   = new_rec;
          state_d = HELD;
        end
      end
      HELD: begin
        if (err_clr_i) begin
          cnt_clr = 1'b1;
          if (viol.viol_valid_i) begin
            rec_d = new_rec;
          end else begin
            rec_d   = '0;
            state_d = IDLE;
          end
        end else if (viol.viol_valid_i) begin
          cnt_inc = 1'b1;
`ifdef IOPMP_ERR_MFR_EN
          rec_d.svw[viol.viol_rrid_i] = 1'b1;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        rec_d   = '0;
      end
    endcase
    intr_d = rec_d.v & intr_en_i;
  end

  // State, record and interrupt registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      rec_q   <= '0;
      intr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rec_q   <= rec_d;
      intr_q  <= intr_d;
    end
  end

  iopmp_sat_cnt #(.W(OVF_CNT_W)) u_ovf_cnt (
    .clk   (clk),
    .rst_n (reset),
    .inc_i (cnt_inc),
    .clr_i (cnt_clr),
    .cnt_o (ovf_cnt_o)
  );

  assign error_report_o = rec_q;
  assign intr_o         = intr_q;

endmodule

// File: tb/tb_iopmp_err_capture.sv
// Randomized self-checking bench for iopmp_err_capture against a behavioural model.
module tb_iopmp_err_capture;
  import iopmp_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic err_clr_i, intr_en_i;
  error_registers_t rep;
  logic [7:0] ovf;
  logic intr;

  always #5 clk = ~clk;

  iopmp_err_capture_if vif ();

  iopmp_err_capture #(.OVF_CNT_W(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .viol           (vif.slave),
    .err_clr_i      (err_clr_i),
    .intr_en_i      (intr_en_i),
    .error_report_o (rep),
    .ovf_cnt_o      (ovf),
    .intr_o         (intr)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: the record as software would see it
  bit                     m_v;
  logic [RW-1:0]          m_rrid;
  logic [33:0]            m_addr;
  logic [1:0]             m_tt;
  logic [2:0]             m_et;
  logic [EW-1:0]          m_eid;
  logic [NUM_MASTERS-1:0] m_svw;
  int                     m_cnt;
  bit                     m_intr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_v = 0; m_rrid = '0; m_addr = '0; m_tt = '0; m_et = '0; m_eid = '0;
    m_svw = '0; m_cnt = 0; m_intr = 0;
  endtask

  task automatic check_all(input string w);
    chk({w, ".v"},     64'(rep.v),     64'(m_v));
    chk({w, ".rrid"},  64'(rep.rrid),  64'(m_rrid));
    chk({w, ".addr"},  64'(rep.addr),  64'(m_addr));
    chk({w, ".ttype"}, 64'(rep.ttype), 64'(m_tt));
    chk({w, ".etype"}, 64'(rep.etype), 64'(m_et));
    chk({w, ".eid"},   64'(rep.eid),   64'(m_eid));
    chk({w, ".svw"},   64'(rep.svw),   64'(m_svw));
    chk({w, ".ovf"},   64'(ovf),       64'(m_cnt));
    chk({w, ".intr"},  64'(intr),      64'(m_intr));
  endtask

  // Drive one cycle of inputs (at negedge), advance model, check at next negedge
  task automatic step(input string w, input bit vv, input logic [RW-1:0] rr,
                      input logic [33:0] ad, input logic [1:0] tt, input logic [2:0] et,
                      input logic [EW-1:0] ei, input bit clr, input bit en);
    bit held;
    vif.viol_valid_i = vv; vif.viol_rrid_i = rr; vif.viol_addr_i = ad;
    vif.viol_ttype_i = tt; vif.viol_etype_i = et; vif.viol_eid_i = ei;
    err_clr_i = clr; intr_en_i = en;
    held = m_v;
    if (vv && (!held || clr)) begin
      m_v = 1; m_rrid = rr; m_addr = ad; m_tt = tt; m_et = et; m_eid = ei;
      m_svw = '0; m_cnt = 0;
    end else if (held && clr) begin
      model_reset();
    end else if (held && vv) begin
      if (m_cnt < 255) m_cnt++;
`ifdef IOPMP_ERR_MFR_EN
      m_svw[rr] = 1'b1;
`endif
    end
    m_intr = m_v && en;
    @(posedge clk);
    @(negedge clk);
    check_all(w);
  endtask

  task automatic rand_step(input string w, input int p_v, input int p_clr, input int p_en);
    logic [RW-1:0] rr;
    logic [31:0]   lo;
    logic [1:0]    hi, tt;
    logic [2:0]    et;
    logic [EW-1:0] ei;
    bit vv, clr, en;
    rr = RW'($urandom_range(0, NUM_MASTERS - 1));
    lo = $urandom();
    hi = 2'($urandom_range(0, 3));
    tt = 2'($urandom_range(1, 3));
    et = 3'($urandom_range(1, 5));
    ei = (et == ETYPE_NO_HIT) ? '0 : EW'($urandom_range(0, NUM_ENTRIES - 1));
    vv  = ($urandom_range(0, 99) < p_v);
    clr = ($urandom_range(0, 99) < p_clr);
    en  = ($urandom_range(0, 99) < p_en);
    step(w, vv, rr, {hi, lo}, tt, et, ei, clr, en);
  endtask

  initial begin
    reset = 1'b0;
    err_clr_i = 0; intr_en_i = 0;
    vif.viol_valid_i = 0; vif.viol_rrid_i = '0; vif.viol_addr_i = '0;
    vif.viol_ttype_i = '0; vif.viol_etype_i = '0; vif.viol_eid_i = '0;
    model_reset();
    @(negedge clk);
    check_all("reset");
    reset = 1'b1;

    // Capture
    step("cap", 1, 2'd2, 34'h1_0000_0040, TTYPE_WRITE, ETYPE_ILL_WRITE, 4'd5, 0, 1);
    chk("cap_v_direct", 64'(rep.v), 64'd1);
    chk("cap_addr_direct", 64'(rep.addr), 64'h1_0000_0040);
    chk("cap_intr_direct", 64'(intr), 64'd1);

    // Overflow saturation
    for (int i = 0; i < 300; i++) rand_step("ovf", 100, 0, 100);
    chk("ovf_sat", 64'(ovf), 64'd255);
    chk("ovf_rec_addr", 64'(rep.addr), 64'h1_0000_0040);

    // Same-cycle clear and capture
    step("clrcap", 1, 2'd1, 34'h0_0000_1000, TTYPE_READ, ETYPE_NO_HIT, 4'd0, 1, 1);
    chk("clrcap_ovf", 64'(ovf), 64'd0);
    chk("clrcap_v", 64'(rep.v), 64'd1);

    // Interrupt enable
    step("ien0", 0, 0, 0, 0, 0, 0, 0, 0);
    chk("ien0_intr", 64'(intr), 64'd0);
    step("ien1", 0, 0, 0, 0, 0, 0, 0, 1);
    chk("ien1_intr", 64'(intr), 64'd1);
    step("clr", 0, 0, 0, 0, 0, 0, 1, 1);
    chk("clr_v", 64'(rep.v), 64'd0);
    step("idleclr", 0, 0, 0, 0, 0, 0, 1, 1);

    // Async reset mid-HELD, between edges
    step("pre_rst", 1, 2'd3, 34'h2_dead_beef, TTYPE_EXEC, ETYPE_ILL_EXEC, 4'd9, 0, 1);
    step("pre_rst2", 1, 2'd0, 34'h0, TTYPE_READ, ETYPE_PARTIAL, 4'd1, 0, 1);
    #2;
    reset = 1'b0;
    vif.viol_valid_i = 1;
    model_reset();
    #1;
    check_all("async_rst");
    @(negedge clk);
    check_all("in_rst");
    reset = 1'b1;
    step("post_rst", 1, 2'd1, 34'h3_0000_0008, TTYPE_READ, ETYPE_ILL_READ, 4'd3, 0, 1);
    chk("post_rst_v", 64'(rep.v), 64'd1);

    // Multi-fault bitmap sequence (svw expected 0 in default build)
    step("mfr_clr", 0, 0, 0, 0, 0, 0, 1, 1);
    step("mfr_cap", 1, 2'd0, 34'h100, TTYPE_READ, ETYPE_ILL_READ, 4'd2, 0, 1);
    step("mfr_r3", 1, 2'd3, 34'h200, TTYPE_WRITE, ETYPE_ILL_WRITE, 4'd4, 0, 1);
    step("mfr_r1", 1, 2'd1, 34'h300, TTYPE_EXEC, ETYPE_ILL_EXEC, 4'd6, 0, 1);
`ifdef IOPMP_ERR_MFR_EN
    chk("mfr_svw", 64'(rep.svw), 64'b1010);
`else
    chk("mfr_svw", 64'(rep.svw), 64'b0);
`endif
    step("mfr_clr2", 0, 0, 0, 0, 0, 0, 1, 1);
    chk("mfr_svw_clr", 64'(rep.svw), 64'b0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) rand_step("rnd", 45, 12, 80);
    for (int i = 0; i < 200; i++) rand_step("rnd_busy", 90, 3, 90);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

endmodule
